// File: rtl/seq_signed_div.sv
// seq_signed_div: iterative restoring signed divider, one quotient bit per clock.
module seq_signed_div #(
  parameter int DIVD_W = 16,
  parameter int DIVR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DIVD_W-1:0] in_dividend_i,
  input  logic [DIVR_W-1:0] in_divisor_i,
  output logic              ready_o,
  output logic              out_valid_o,
  output logic [DIVD_W-1:0] quotient_o,
  output logic [DIVR_W-1:0] remainder_o,
  output logic              dbz_o,
  output logic              ovf_o
);
  localparam int CW = $clog2(DIVD_W + 1);
  localparam logic [DIVD_W-1:0] DIVD_MIN = {1'b1, {(DIVD_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [DIVD_W-1:0] dvd, divd_mag, q_fix;
  logic [DIVR_W-1:0] dvr, prem, divr_mag, r_fix;
  logic [DIVR_W:0] shl, diff;
  logic [CW-1:0] cntr;
  logic sign_q, sign_r, dbz, ovf;
  assign ready_o = state == IDLE;
  // Magnitudes are unsigned, so the most-negative operand still fits.
  always_comb begin
    divd_mag = in_dividend_i[DIVD_W-1] ? -in_dividend_i : in_dividend_i;
    divr_mag = in_divisor_i[DIVR_W-1] ? -in_divisor_i : in_divisor_i;
    shl = {prem, dvd[DIVD_W-1]};
    diff = shl - {1'b0, dvr};
    q_fix = sign_q ? -dvd : dvd;
    r_fix = sign_r ? -prem : prem;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd <= '0;
      dvr <= '0;
      prem <= '0;
      cntr <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dbz <= 1'b0;
      ovf <= 1'b0;
      out_valid_o <= 1'b0;
      quotient_o <= '0;
      remainder_o <= '0;
      dbz_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      if (state == IDLE) begin
        if (in_valid_i) begin
          dvd <= divd_mag;
          dvr <= divr_mag;
          prem <= '0;
          cntr <= CW'(DIVD_W);
          sign_q <= in_dividend_i[DIVD_W-1] ^ in_divisor_i[DIVR_W-1];
          sign_r <= in_dividend_i[DIVD_W-1];
          dbz <= in_divisor_i == '0;
          ovf <= in_dividend_i == DIVD_MIN && in_divisor_i == '1;
          state <= CALC;
        end
      end else if (state == CALC) begin
        // Quotient bits shift into the dividend register as it empties.
        prem <= diff[DIVR_W] ? shl[DIVR_W-1:0] : diff[DIVR_W-1:0];
        dvd <= {dvd[DIVD_W-2:0], ~diff[DIVR_W]};
        cntr <= cntr - 1'b1;
        if (cntr == CW'(1)) state <= FIX;
      end else begin
        quotient_o <= dbz ? '0 : ovf ? DIVD_MIN : q_fix;
        remainder_o <= (dbz || ovf) ? '0 : r_fix;
        dbz_o <= dbz;
        ovf_o <= ovf;
        out_valid_o <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_signed_div.sv
// tb_seq_signed_div: directed and random scoreboard checks for seq_signed_div.
module tb_seq_signed_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic ready, out_valid, dbz, ovf;
  logic [15:0] quotient;
  logic [7:0] remainder;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    int a;
    int b;
    logic [15:0] q;
    logic [7:0] r;
    logic dbz;
    logic ovf;
    int cyc;
  } exp_t;
  exp_t sb[$];

  seq_signed_div #(.DIVD_W(16), .DIVR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_dividend_i(dividend),
    .in_divisor_i(divisor), .ready_o(ready), .out_valid_o(out_valid),
    .quotient_o(quotient), .remainder_o(remainder), .dbz_o(dbz), .ovf_o(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.dbz = b == 0;
    e.ovf = a == -32768 && b == -1;
    e.q = e.dbz ? 16'h0 : e.ovf ? 16'h8000 : 16'(a / b);
    e.r = (e.dbz || e.ovf) ? 8'h0 : 8'(a % b);
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        int qs, rs;
        bit inv;
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("dbz", dbz, e.dbz);
        chk("ovf", ovf, e.ovf);
        if (!e.dbz && !e.ovf) begin
          qs = int'($signed(quotient));
          rs = int'($signed(remainder));
          inv = (qs * e.b + rs == e.a) && ((rs < 0 ? -rs : rs) < (e.b < 0 ? -e.b : e.b))
                && (rs == 0 || ((rs < 0) == (e.a < 0)));
          chk("invariant", inv, 1);
        end
      end
    end
  end

  task automatic send(input int a, input int b, input bit push);
    int n = 0;
    exp_t e;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
    in_valid = 1'b1;
    dividend = 16'(a);
    divisor = 8'(b);
    if (push) begin
      e = model(a, b);
      e.cyc = cyc + 18;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int a, b;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(100, 7, 1);
    chk("busy_ready", ready, 0);
    send(-100, 7, 1);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'h1111;
      divisor = 8'h03;
      @(negedge clk);
      in_valid = 1'b0;
    end
    send(100, -7, 1);
    send(-100, -7, 1);
    send(-128, -128, 1);
    send(-32768, -1, 1);
    send(1234, 0, 1);
    send(32767, 1, 1);
    send(-32768, 127, 1);
    send(100, 7, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_on_out_valid", out_valid, 1);
    send(50, 5, 1);
    send(100, 7, 0);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_flags", {dbz, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    send(9, 3, 1);
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0: a = -32768;
        1: a = 32767;
        2: a = int'($urandom_range(0, 2)) - 1;
        default: a = int'($urandom_range(0, 65535)) - 32768;
      endcase
      case ($urandom_range(0, 6))
        0: b = -128;
        1: b = 127;
        2: b = 1;
        3: b = -1;
        4: b = 0;
        default: b = int'($urandom_range(0, 255)) - 128;
      endcase
      send(a, b, 1);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
